ccd_row_buffer: RTL and testbench

Two-line ping-pong row buffer for the CCD edge path. It accepts the raw 10-bit pixel stream, stores each line in one of two alternating line RAMs, and presents each current pixel together with the pixel directly above it. Its outputs are the `rama`/`ramb` data, the `sel_row1`/`sel_row2` qualifiers and the `row_end` strobe consumed by the downstream 2x2 window mux. It tracks frame and line position and ignores pixels outside an active frame.

---
 rtl/ccd_row_buffer.sv | 118 +++++++++++
 tb/tb_ccd_row_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ccd_row_buffer.sv
// rtl/ccd_row_buffer.sv - two-line ping-pong row buffer pairing each pixel with the pixel above it
//
// Ports:
//   clk          rising-edge clock
//   aclr         synchronous active-low reset
//   frame_start  one-cycle pulse starting (or restarting) a frame
//   pix_valid    pix_in carries a pixel this cycle
//   pix_in       incoming pixel
//   rama         previous-line pixel at the same column (0 on line 0)
//   ramb         current-line pixel, aligned with rama
//   sel_row1     rama is valid
//   sel_row2     ramb is valid
//   row_end      output beat of the last column of a line
//   frame_done   output beat of the last pixel of the frame
module ccd_row_buffer #(
    parameter int DATA_W = 10,
    parameter int LINE_W = 640,
    parameter int LINES  = 480,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic [DATA_W-1:0] rama,
    output logic [DATA_W-1:0] ramb,
    output logic              sel_row1,
    output logic              sel_row2,
    output logic              row_end,
    output logic              frame_done
);

    localparam int LN_W = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] col, col_n, cur_col;
    logic [LN_W-1:0]   line, line_n, cur_line;
    logic              wr_sel, wr_sel_n, cur_sel;
    logic              beat, last_col, last_line;

    logic [DATA_W-1:0] mem0 [LINE_W];
    logic [DATA_W-1:0] mem1 [LINE_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (!aclr) begin
            state      <= IDLE;
            col        <= '0;
            line       <= '0;
            wr_sel     <= 1'b0;
            ramb       <= '0;
            sel_row1   <= 1'b0;
            sel_row2   <= 1'b0;
            row_end    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            line       <= line_n;
            wr_sel     <= wr_sel_n;
            ramb       <= beat ? pix_in : '0;
            sel_row1   <= beat && (cur_line != '0);
            sel_row2   <= beat;
            row_end    <= beat && last_col;
            frame_done <= beat && last_col && last_line;
        end
    end

    always_comb begin
        // A frame_start re-initialises position before the simultaneous beat
        // is applied, so that beat lands on (0,0) of the new frame.
        cur_col   = frame_start ? '0 : col;
        cur_line  = frame_start ? '0 : line;
        cur_sel   = frame_start ? 1'b0 : wr_sel;
        beat      = pix_valid && (state == ACTIVE);
        last_col  = (cur_col == ADDR_W'(LINE_W - 1));
        last_line = (cur_line == LN_W'(LINES - 1));

        state_n  = frame_start ? ACTIVE : state;
        col_n    = cur_col;
        line_n   = cur_line;
        wr_sel_n = cur_sel;

        if (beat) begin
            if (last_col) begin
                col_n    = '0;
                wr_sel_n = ~cur_sel;
                if (last_line) begin
                    line_n  = '0;
                    state_n = IDLE;
                end else begin
                    line_n = cur_line + 1'b1;
                end
            end else begin
                col_n = cur_col + 1'b1;
            end
        end
    end

    // Line RAMs are never reset; stale data on line 0 is masked via sel_row1.
    always_ff @(posedge clk) begin
        if (beat) begin
            if (cur_sel) begin
                mem1[cur_col] <= pix_in;
                rd_q          <= mem0[cur_col];
            end else begin
                mem0[cur_col] <= pix_in;
                rd_q          <= mem1[cur_col];
            end
        end
    end

    assign rama = sel_row1 ? rd_q : '0;

endmodule

// File: tb/tb_ccd_row_buffer.sv
// tb/tb_ccd_row_buffer.sv - self-checking bench for ccd_row_buffer
module tb_ccd_row_buffer;

    localparam int DW = 10;
    localparam int LW = 4;
    localparam int NL = 3;

    logic          clk = 1'b0;
    logic          aclr = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic [DW-1:0] rama, ramb;
    logic          sel_row1, sel_row2, row_end, frame_done;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    ccd_row_buffer #(.DATA_W(DW), .LINE_W(LW), .LINES(NL), .ADDR_W(2)) dut (
        .clk(clk), .aclr(aclr), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_in(pix_in), .rama(rama), .ramb(ramb), .sel_row1(sel_row1),
        .sel_row2(sel_row2), .row_end(row_end), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Frame-level model: image indexed by (line, column) of the current frame.
    int img [NL][LW];
    int m_col = 0, m_line = 0;
    bit m_active = 1'b0;
    int e_rama = 0, e_ramb = 0;
    bit e_s1 = 0, e_s2 = 0, e_re = 0, e_fd = 0;

    always @(posedge clk) begin
        bit b;
        if (!aclr) begin
            m_active = 0; m_col = 0; m_line = 0;
            e_rama = 0; e_ramb = 0; e_s1 = 0; e_s2 = 0; e_re = 0; e_fd = 0;
        end else begin
            b = pix_valid && m_active;
            if (frame_start) begin
                m_active = 1; m_col = 0; m_line = 0;
            end
            if (b) begin
                img[m_line][m_col] = int'(pix_in);
                e_ramb = int'(pix_in);
                e_rama = (m_line > 0) ? img[m_line-1][m_col] : 0;
                e_s1 = (m_line > 0);
                e_s2 = 1;
                e_re = (m_col == LW - 1);
                e_fd = e_re && (m_line == NL - 1);
                m_col++;
                if (m_col == LW) begin
                    m_col = 0;
                    m_line++;
                    if (m_line == NL) begin
                        m_line = 0;
                        m_active = 0;
                    end
                end
            end else begin
                e_rama = 0; e_ramb = 0; e_s1 = 0; e_s2 = 0; e_re = 0; e_fd = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            checks++;
            if (int'(rama) != e_rama || int'(ramb) != e_ramb || sel_row1 != e_s1 ||
                sel_row2 != e_s2 || row_end != e_re || frame_done != e_fd) begin
                failures++;
                $display("FAIL model t=%0t got rama=%0d ramb=%0d s1=%0d s2=%0d re=%0d fd=%0d exp rama=%0d ramb=%0d s1=%0d s2=%0d re=%0d fd=%0d",
                         $time, rama, ramb, sel_row1, sel_row2, row_end, frame_done,
                         e_rama, e_ramb, e_s1, e_s2, e_re, e_fd);
            end
        end
    end

    task automatic step(input bit fs, input bit pv, input int p, input bit ac = 1'b1);
        frame_start = fs;
        pix_valid   = pv;
        pix_in      = DW'(p);
        aclr        = ac;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    // Literal check of the full output vector {rama, ramb, s1, s2, re, fd}.
    task automatic lit(input string name, input int ea, input int eb,
                       input bit s1, input bit s2, input bit re, input bit fd);
        checks++;
        if (int'(rama) != ea || int'(ramb) != eb || sel_row1 != s1 ||
            sel_row2 != s2 || row_end != re || frame_done != fd) begin
            failures++;
            $display("FAIL %s got rama=%0d ramb=%0d s1=%0d s2=%0d re=%0d fd=%0d exp rama=%0d ramb=%0d s1=%0d s2=%0d re=%0d fd=%0d",
                     name, rama, ramb, sel_row1, sel_row2, row_end, frame_done,
                     ea, eb, s1, s2, re, fd);
        end
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        lit("reset", 0, 0, 0, 0, 0, 0);
        run_cmp = 1'b1;

        // Beats before any frame_start are ignored.
        for (int i = 0; i < 3; i++) step(0, 1, 50 + i);
        lit("idle_ignore", 0, 0, 0, 0, 0, 0);

        // Full frame 0..11.
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, i);
            if (i == 3)  lit("l0_end", 0, 3, 0, 1, 1, 0);
            if (i == 5)  lit("l1_c1", 1, 5, 1, 1, 0, 0);
            if (i == 10) lit("l2_c2", 6, 10, 1, 1, 0, 0);
            if (i == 11) lit("frame_end", 7, 11, 1, 1, 1, 1);
        end
        step(0, 1, 99);
        lit("idle_after_frame", 0, 0, 0, 0, 0, 0);

        // Frame with a 2-cycle gap after the sixth pixel.
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 100 + i);
            if (i == 5) begin
                step(0, 0, 0);
                lit("gap1", 0, 0, 0, 0, 0, 0);
                step(0, 0, 0);
                lit("gap2", 0, 0, 0, 0, 0, 0);
            end
            if (i == 6)  lit("after_gap", 102, 106, 1, 1, 0, 0);
            if (i == 11) lit("gap_frame_end", 107, 111, 1, 1, 1, 1);
        end

        // frame_start with a beat in the middle of line 1.
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 200 + i);
        step(1, 1, 206);
        lit("abort_pix", 0, 206, 0, 1, 0, 0);
        for (int i = 7; i < 11; i++) step(0, 1, 200 + i);
        lit("abort_l1c0", 206, 210, 1, 1, 0, 0);

        // Reset pulse during line 1.
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 250 + i);
        step(0, 1, 256, 0);
        lit("mid_reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 260 + i);
        lit("post_reset_idle", 0, 0, 0, 0, 0, 0);

        // Back-to-back frames.
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 300 + i);
        lit("b2b_done", 307, 311, 1, 1, 1, 1);
        step(1, 0, 0);
        step(0, 1, 400);
        lit("b2b_l0c0", 0, 400, 0, 1, 0, 0);
        for (int i = 1; i < 5; i++) step(0, 1, 400 + i);
        lit("b2b_l1c0", 400, 404, 1, 1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
